// File: rtl/game_round_controller_pkg.sv
// game_round_controller_pkg: shared FSM state encoding and default timing constants
// for the round controller and its edge detector.
package game_round_controller_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GEN    = 3'd1,
        LOAD   = 3'd2,
        WAIT   = 3'd3,
        RESULT = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam int          DEF_ROUNDS         = 8;
    localparam logic [23:0] DEF_TIMEOUT_CYCLES = 24'd10_000_000;
    localparam logic [23:0] DEF_RESULT_CYCLES  = 24'd5_000_000;

endpackage

// File: rtl/game_round_controller_edge_detect.sv
// edge_detect: registered history of a level input plus a one-cycle rising-edge pulse.
//   clk   in  system clock, rising edge
//   rst_n in  asynchronous active-low reset
//   d     in  level input (already synchronised)
//   rise  out high for the cycle in which d is first seen high
module edge_detect
    import game_round_controller_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic prev_q, prev_d;
    logic armed_q, armed_d;

    always_comb begin
        prev_d  = d;
        armed_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            armed_q <= armed_d;
        end
    end

    // The first cycle after reset only samples the history, so a button held
    // through reset is not mistaken for a fresh press.
    assign rise = armed_q & d & ~prev_q;

endmodule

// File: rtl/game_round_controller.sv
// game_round_controller: number-matching game sequencer (start, random target, answer
// window, result display, score keeping over ROUNDS rounds).
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   start_btn           start request level; one game per rising edge in IDLE/DONE
//   submit_btn          answer-submit level; evaluated on rising edge in WAIT
//   answer_in[7:0]      player's answer
//   rng_value[7:0]      external random number generator output
//   rng_trigger         one-cycle capture request to the generator
//   target_out[7:0]     number the player must enter
//   round_active        waiting for an answer
//   correct/wrong       last answer result, held during the result display
//   timeout             answer window expired (only with GAME_TIMEOUT_EN)
//   score[7:0]          correct answers this game, saturating
//   round_cnt[7:0]      completed rounds this game
//   game_over           game finished
// Build option: define GAME_TIMEOUT_EN to bound the answer window by TIMEOUT_CYCLES;
// otherwise WAIT lasts until a submit and no timer exists.
module game_round_controller
    import game_round_controller_pkg::*;
#(
    parameter int          ROUNDS         = DEF_ROUNDS,
    parameter logic [23:0] TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter logic [23:0] RESULT_CYCLES  = DEF_RESULT_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_btn,
    input  logic       submit_btn,
    input  logic [7:0] answer_in,
    input  logic [7:0] rng_value,
    output logic       rng_trigger,
    output logic [7:0] target_out,
    output logic       round_active,
    output logic       correct,
    output logic       wrong,
    output logic       timeout,
    output logic [7:0] score,
    output logic [7:0] round_cnt,
    output logic       game_over
);

    localparam logic [7:0] ROUNDS_B = 8'(ROUNDS);

    if (ROUNDS < 1 || ROUNDS > 255 || TIMEOUT_CYCLES == 24'd0 || RESULT_CYCLES == 24'd0) begin : g_cfg_check
        $error("game_round_controller: ROUNDS must be 1..255 and cycle counts nonzero");
    end

    state_t      state_q, state_d;
    logic [7:0]  target_q, target_d;
    logic [7:0]  score_q, score_d;
    logic [7:0]  round_cnt_q, round_cnt_d;
    logic        correct_q, correct_d;
    logic        wrong_q, wrong_d;
    logic [23:0] hold_q, hold_d;
    logic        start_rise, submit_rise;
    logic        hit;
    logic        expired;

    edge_detect u_start_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (start_btn),
        .rise  (start_rise)
    );

    edge_detect u_submit_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (submit_btn),
        .rise  (submit_rise)
    );

    assign hit = submit_rise && (answer_in == target_q);

`ifdef GAME_TIMEOUT_EN
    logic [23:0] timer_q, timer_d;
    logic        timeout_q, timeout_d;

    assign expired = (timer_q == 24'd0);

    // A submit in the final window cycle wins, so timeout only flags when no submit arrived.
    always_comb begin
        timer_d   = timer_q;
        timeout_d = timeout_q;
        if (state_q == LOAD) begin
            timer_d = TIMEOUT_CYCLES - 24'd1;
        end else if (state_q == WAIT) begin
            timer_d   = expired ? timer_q : timer_q - 24'd1;
            timeout_d = !submit_rise && expired;
        end else if (state_q == RESULT && hold_q == 24'd0) begin
            timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q   <= 24'd0;
            timeout_q <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign expired = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        score_d     = score_q;
        round_cnt_d = round_cnt_q;
        correct_d   = correct_q;
        wrong_d     = wrong_q;
        hold_d      = hold_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_rise) begin
                    score_d     = 8'd0;
                    round_cnt_d = 8'd0;
                    state_d     = GEN;
                end
            end
            GEN: state_d = LOAD;
            LOAD: begin
                // Zero is unplayable: keep the old target and request another number.
                if (rng_value == 8'd0) begin
                    state_d = GEN;
                end else begin
                    target_d = rng_value;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (submit_rise || expired) begin
                    correct_d   = hit;
                    wrong_d     = !hit;
                    score_d     = (hit && score_q != 8'hFF) ? score_q + 8'd1 : score_q;
                    round_cnt_d = round_cnt_q + 8'd1;
                    hold_d      = RESULT_CYCLES - 24'd1;
                    state_d     = RESULT;
                end
            end
            RESULT: begin
                if (hold_q == 24'd0) begin
                    correct_d = 1'b0;
                    wrong_d   = 1'b0;
                    state_d   = (round_cnt_q == ROUNDS_B) ? DONE : GEN;
                end else begin
                    hold_d = hold_q - 24'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            target_q    <= 8'd0;
            score_q     <= 8'd0;
            round_cnt_q <= 8'd0;
            correct_q   <= 1'b0;
            wrong_q     <= 1'b0;
            hold_q      <= 24'd0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            score_q     <= score_d;
            round_cnt_q <= round_cnt_d;
            correct_q   <= correct_d;
            wrong_q     <= wrong_d;
            hold_q      <= hold_d;
        end
    end

    assign rng_trigger  = (state_q == GEN);
    assign target_out   = target_q;
    assign round_active = (state_q == WAIT);
    assign correct      = correct_q;
    assign wrong        = wrong_q;
    assign score        = score_q;
    assign round_cnt    = round_cnt_q;
    assign game_over    = (state_q == DONE);

endmodule

// File: tb/tb_game_round_controller.sv
// tb_game_round_controller: self-checking bench for game_round_controller with a small
// LFSR standing in for the random number generator.
module tb_game_round_controller;

    localparam int R  = 2;
    localparam int T  = 20;
    localparam int RC = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_btn = 1'b0;
    logic       submit_btn = 1'b0;
    logic [7:0] answer_in = 8'd0;
    logic [7:0] rng_value;
    logic       rng_trigger;
    logic [7:0] target_out;
    logic       round_active, correct, wrong, timeout, game_over;
    logic [7:0] score, round_cnt;

    game_round_controller #(
        .ROUNDS         (R),
        .TIMEOUT_CYCLES (24'(T)),
        .RESULT_CYCLES  (24'(RC))
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_btn    (start_btn),
        .submit_btn   (submit_btn),
        .answer_in    (answer_in),
        .rng_value    (rng_value),
        .rng_trigger  (rng_trigger),
        .target_out   (target_out),
        .round_active (round_active),
        .correct      (correct),
        .wrong        (wrong),
        .timeout      (timeout),
        .score        (score),
        .round_cnt    (round_cnt),
        .game_over    (game_over)
    );

    always #5 clk = ~clk;

    // Random number generator: maximal 8-bit LFSR stepped on each capture request.
    logic [7:0] rng_q = 8'h5A;
    logic       force_zero = 1'b0;
    always @(posedge clk) if (rng_trigger) rng_q <= {rng_q[6:0], rng_q[7] ^ rng_q[5] ^ rng_q[4] ^ rng_q[3]};
    assign rng_value = force_zero ? 8'h00 : rng_q;

    int   trig_cnt = 0, consec = 0, zero_tgt = 0;
    logic prev_trig = 1'b0;
    always @(negedge clk) begin
        if (rng_trigger && prev_trig) consec++;
        if (rng_trigger) trig_cnt++;
        if (round_active && target_out == 8'h00) zero_tgt++;
        prev_trig = rng_trigger;
    end

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_start();
        start_btn = 1'b1;
        tick(1);
        start_btn = 1'b0;
    endtask

    task automatic submit(input logic [7:0] ans);
        answer_in  = ans;
        submit_btn = 1'b1;
        tick(1);
        submit_btn = 1'b0;
    endtask

    task automatic wait_active(input string nm);
        int k = 0;
        while (!round_active && k < 50) begin
            tick(1);
            k++;
        end
        chk(nm, round_active, 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start_btn = 1'b0;
        submit_btn = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    typedef struct {
        logic       new_game;
        logic       right;
        int         delay;
        logic       exp_c;
        logic       exp_w;
        logic [7:0] exp_score;
        logic [7:0] exp_rounds;
        logic       exp_over;
    } vec_t;

    vec_t vec [4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int trig_base, score_m, base;
        logic right;
        logic [7:0] flip;

        vec[0] = '{1'b1, 1'b1, 0,     1'b1, 1'b0, 8'd1, 8'd1, 1'b0};
        vec[1] = '{1'b0, 1'b1, 5,     1'b1, 1'b0, 8'd2, 8'd2, 1'b1};
        vec[2] = '{1'b1, 1'b0, 3,     1'b0, 1'b1, 8'd0, 8'd1, 1'b0};
        vec[3] = '{1'b0, 1'b1, T - 3, 1'b1, 1'b0, 8'd1, 8'd2, 1'b1};

        tick(3);
        chk("reset flags", {rng_trigger, round_active, correct, wrong, timeout, game_over}, 0);
        chk("reset score", score, 0);
        chk("reset round_cnt", round_cnt, 0);
        chk("reset target", target_out, 0);
        rst_n = 1'b1;
        tick(2);
        chk("idle after release", {rng_trigger, round_active, game_over}, 0);

        trig_base = 0;
        for (int i = 0; i < 4; i++) begin
            if (vec[i].new_game) begin
                trig_base = trig_cnt;
                press_start();
            end
            wait_active("tbl reach wait");
            chk("tbl target", target_out, rng_q);
            tick(vec[i].delay);
            submit(vec[i].right ? rng_q : rng_q ^ 8'h01);
            for (int k = 0; k < RC; k++) begin
                chk("tbl correct", correct, vec[i].exp_c);
                chk("tbl wrong", wrong, vec[i].exp_w);
                chk("tbl score", score, vec[i].exp_score);
                chk("tbl round_cnt", round_cnt, vec[i].exp_rounds);
                tick(1);
            end
            chk("tbl game_over", game_over, vec[i].exp_over);
            chk("tbl flags cleared", {correct, wrong, timeout}, 0);
            chk("tbl next trigger", rng_trigger, !vec[i].exp_over);
            if (vec[i].exp_over) chk("tbl triggers per game", trig_cnt - trig_base, R);
        end

        for (int g = 0; g < 6; g++) begin
            score_m   = 0;
            trig_base = trig_cnt;
            press_start();
            for (int r = 0; r < R; r++) begin
                wait_active("rnd reach wait");
                chk("rnd target", target_out, rng_q);
                if ($urandom_range(0, 1) == 1) press_start();
                tick($urandom_range(0, 12));
                right = 1'($urandom_range(0, 1));
                flip  = 8'($urandom_range(1, 255));
                submit(right ? rng_q : rng_q ^ flip);
                score_m += right ? 1 : 0;
                chk("rnd correct", correct, right);
                chk("rnd wrong", wrong, !right);
                chk("rnd score", score, score_m);
                chk("rnd round_cnt", round_cnt, r + 1);
                submit(8'h00);
                tick(RC - 1);
                chk("rnd score held", score, score_m);
                chk("rnd game_over", game_over, r == R - 1);
            end
            chk("rnd triggers per game", trig_cnt - trig_base, R);
        end

`ifdef GAME_TIMEOUT_EN
        press_start();
        wait_active("to reach wait");
        tick(T - 1);
        chk("to last window cycle", round_active, 1);
        tick(1);
        chk("to timeout", timeout, 1);
        chk("to wrong", wrong, 1);
        chk("to correct", correct, 0);
        chk("to score", score, 0);
        tick(RC);
        wait_active("to reach wait 2");
        tick(T - 1);
        submit(rng_q);
        chk("to submit priority correct", correct, 1);
        chk("to submit priority timeout", timeout, 0);
        chk("to submit priority score", score, 1);
        tick(RC);
        chk("to game_over", game_over, 1);
`else
        press_start();
        wait_active("nto reach wait");
        tick(1000);
        chk("nto still waiting", round_active, 1);
        chk("nto no timeout", {timeout, wrong}, 0);
`endif
        do_reset();

        press_start();
        wait_active("rst reach wait 1");
        submit(rng_q);
        tick(RC);
        wait_active("rst reach wait 2");
        chk("rst score before", score, 1);
        #2;
        rst_n = 1'b0;
        start_btn = 1'b1;
        submit_btn = 1'b1;
        answer_in = rng_q;
        #1;
        chk("rst async flags", {rng_trigger, round_active, correct, wrong, timeout, game_over}, 0);
        chk("rst async score", score, 0);
        chk("rst async round_cnt", round_cnt, 0);
        chk("rst async target", target_out, 0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        chk("rst idle after release", {rng_trigger, round_active, game_over}, 0);
        base = trig_cnt;
        tick(5);
        chk("rst held start no edge", trig_cnt - base, 0);
        chk("rst held submit no score", score, 0);
        start_btn = 1'b0;
        submit_btn = 1'b0;
        tick(1);
        press_start();
        chk("rst restart trigger", rng_trigger, 1);
        wait_active("rst restart wait");
        chk("rst restart score", score, 0);
        chk("rst restart round_cnt", round_cnt, 0);
        do_reset();

        base = trig_cnt;
        force_zero = 1'b1;
        press_start();
        chk("zero first trigger", rng_trigger, 1);
        tick(1);
        chk("zero load cycle", rng_trigger, 0);
        tick(1);
        chk("zero second trigger", rng_trigger, 1);
        force_zero = 1'b0;
        tick(2);
        chk("zero reach wait", round_active, 1);
        chk("zero target", target_out, rng_q);
        chk("zero trigger count", trig_cnt - base, 2);

        chk("no back-to-back triggers", consec, 0);
        chk("target never zero in wait", zero_tgt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
